// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns an execute-stage load/store into a req/gnt/rvalid
// transaction on the data memory port. It stalls the core while the access
// is in flight and returns sign/zero-extended load data.
module lsu_mem_ctrl #(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned AWIDTH  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              memren_i,
  input  logic              memwren_i,
  input  logic [2:0]        funct3_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic              stall_o,
  output logic [DWIDTH-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DWIDTH-1:0] mem_rdata_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q;
  logic [AWIDTH-1:0] addr_q;
  logic [3:0]        be_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [DWIDTH-1:0] rdata_q;

  logic              legal;
  logic [3:0]        be_d;
  logic [DWIDTH-1:0] wdata_d;
  logic [DWIDTH-1:0] shifted;
  logic [DWIDTH-1:0] ext_data;
  logic              timeout_hit;

  // Request legality: conflicting strobes, unsupported funct3, misalignment
  always_comb begin
    legal = 1'b1;
    if (memren_i && memwren_i) begin
      legal = 1'b0;
    end else if (memren_i) begin
      legal = funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end else if (memwren_i) begin
      legal = funct3_i inside {3'b000, 3'b001, 3'b010};
    end
    if (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00) legal = 1'b0;
    if (funct3_i[1:0] == 2'b01 && addr_i[0]) legal = 1'b0;
  end

  // Byte enables and lane-replicated store data
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = wdata_i;
    if (memwren_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          be_d    = 4'b0001 << addr_i[1:0];
          wdata_d = {4{wdata_i[7:0]}};
        end
        2'b01: begin
          be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{wdata_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Align the addressed lane to bit 0 and extend per the registered funct3
  always_comb begin
    shifted = mem_rdata_i >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ext_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ext_data = {24'd0, shifted[7:0]};
      3'b101:  ext_data = {16'd0, shifted[15:0]};
      default: ext_data = shifted;
    endcase
  end

  // A real rvalid in the last allowed WAIT cycle still wins over the abort
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1)) && !mem_rvalid_i;

  // Next state, stall and error; stall/err are forced low while in reset
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    stall_o = 1'b0;
    err_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (memren_i || memwren_i) begin
          if (legal) begin
            stall_o = 1'b1;
            state_d = REQ;
          end else begin
            err_o = 1'b1;
          end
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (mem_gnt_i) state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        stall_o = 1'b1;
        if (mem_rvalid_i) begin
          state_d = DONE;
        end else if (timeout_hit) begin
          // Release the core so it does not re-issue the aborted access
          stall_o = 1'b0;
          err_o   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst_ni) begin
      stall_o = 1'b0;
      err_o   = 1'b0;
    end
  end

  // State, timeout counter and captured request fields
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && (memren_i || memwren_i) && legal) begin
        we_q    <= memwren_i;
        addr_q  <= {addr_i[AWIDTH-1:2], 2'b00};
        be_q    <= be_d;
        wdata_q <= wdata_d;
        f3_q    <= funct3_i;
        off_q   <= addr_i[1:0];
      end
      if (state_q == WAIT && mem_rvalid_i) rdata_q <= ext_data;
    end
  end

  assign mem_req_o     = (state_q == REQ);
  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_be_o      = be_q;
  assign mem_wdata_o   = wdata_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = (state_q == DONE) && !we_q;

endmodule
